sd_dma_wb_arbiter: RTL

SD_DMA_WB_ARBITER -- requirements
Module: sd_dma_wb_arbiter

---
 rtl/sd_dma_wb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sd_dma_wb_arbiter.sv
// Two-master Wishbone arbiter for the SD DMA TX/RX fillers.
// The arbiter uses round-robin grant in IDLE and a registered one-hot grant.
// Bus signals are a combinational mux of the granted master.
// A granted master is preempted after MAX_BEATS acks, but only if the other
// master is waiting. A cycle is aborted if a stalled strobe times out.
module sd_dma_wb_arbiter #(
    parameter int MAX_BEATS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m_cyc_i,
    input  logic [1:0]  m_stb_i,
    input  logic [1:0]  m_we_i,
    input  logic [63:0] m_adr_i,
    input  logic [63:0] m_dat_i,
    input  logic [5:0]  m_cti_i,
    input  logic [3:0]  m_bte_i,
    output logic [1:0]  m_ack_o,
    output logic [1:0]  m_err_o,
    output logic [31:0] m_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        last_gnt_r;
    logic        last_gnt_next_s;
    logic [1:0]  gnt_r;
    logic [1:0]  gnt_next_s;
    logic [3:0]  beat_cnt_r;
    logic [7:0]  to_cnt_r;

    logic        granted_s;
    logic        sel_s;
    logic        cur_cyc_s;
    logic        cur_stb_s;
    logic        other_req_s;
    logic        preempt_s;
    logic        timeout_s;
    logic        bus_on_s;
    logic        ack_s;

    // Read data is broadcast; only the acked master consumes it.
    assign m_dat_o = wb_dat_i;
    assign gnt_o   = gnt_r;

    // Select the granted master and derive the preempt and timeout conditions.
    always_comb begin
        granted_s   = (state_r != IDLE);
        sel_s       = (state_r == GNT1);
        cur_cyc_s   = sel_s ? m_cyc_i[1] : m_cyc_i[0];
        cur_stb_s   = sel_s ? m_stb_i[1] : m_stb_i[0];
        other_req_s = sel_s ? m_cyc_i[0] : m_cyc_i[1];
        preempt_s   = granted_s & (beat_cnt_r == 4'(MAX_BEATS)) & other_req_s;
        // An ack in the timeout cycle wins, so a timeout requires no ack.
        timeout_s   = granted_s & cur_stb_s & ~preempt_s & ~wb_ack_i
                      & (to_cnt_r == 8'(TIMEOUT));
        bus_on_s    = granted_s & ~preempt_s & ~timeout_s;
    end

    // Drive the shared bus from the granted master; it is all zero in IDLE.
    always_comb begin
        wb_cyc_o = bus_on_s & cur_cyc_s;
        wb_stb_o = bus_on_s & cur_stb_s;
        if (granted_s) begin
            wb_we_o  = sel_s ? m_we_i[1]        : m_we_i[0];
            wb_adr_o = sel_s ? m_adr_i[63:32]   : m_adr_i[31:0];
            wb_dat_o = sel_s ? m_dat_i[63:32]   : m_dat_i[31:0];
            wb_cti_o = sel_s ? m_cti_i[5:3]     : m_cti_i[2:0];
            wb_bte_o = sel_s ? m_bte_i[3:2]     : m_bte_i[1:0];
        end else begin
            wb_we_o  = 1'b0;
            wb_adr_o = 32'd0;
            wb_dat_o = 32'd0;
            wb_cti_o = 3'd0;
            wb_bte_o = 2'd0;
        end
    end

    // Route ack and timeout error to the granted master only.
    always_comb begin
        ack_s   = wb_ack_i & wb_stb_o;
        m_ack_o = {ack_s & gnt_r[1], ack_s & gnt_r[0]};
        m_err_o = {timeout_s & sel_s, timeout_s & ~sel_s};
    end

    // Next-state logic: round-robin arbitration and grant release.
    always_comb begin
        state_next_s    = state_r;
        last_gnt_next_s = last_gnt_r;
        gnt_next_s      = 2'b00;
        case (state_r)
            IDLE: begin
                if (m_cyc_i == 2'b11) begin
                    state_next_s = last_gnt_r ? GNT0 : GNT1;
                end else if (m_cyc_i[0]) begin
                    state_next_s = GNT0;
                end else if (m_cyc_i[1]) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (~cur_cyc_s | preempt_s | timeout_s) begin
                    state_next_s    = IDLE;
                    last_gnt_next_s = sel_s;
                end else begin
                    state_next_s    = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        case (state_next_s)
            GNT0:    gnt_next_s = 2'b01;
            GNT1:    gnt_next_s = 2'b10;
            default: gnt_next_s = 2'b00;
        endcase
    end

    // State, last-grant and registered one-hot grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b1;
            gnt_r      <= 2'b00;
        end else begin
            state_r    <= state_next_s;
            last_gnt_r <= last_gnt_next_s;
            gnt_r      <= gnt_next_s;
        end
    end

    // Beat counter; it is held at zero in IDLE, so every grant starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            beat_cnt_r <= 4'd0;
        end else if (ack_s && (beat_cnt_r != 4'hF)) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Stall timer: it counts granted strobe cycles that have no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= 8'd0;
        end else if ((state_r == IDLE) || ack_s || !wb_stb_o) begin
            to_cnt_r <= 8'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 8'd1;
        end
    end

endmodule
